// File: rtl/lsu_mem_port.sv
// +----------------------------------------------------------------------------+
// | lsu_mem_port : load/store unit bridging execute stage and data memory port |
// | Splits or faults word-crossing accesses; merges and extends load data.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_port #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic                req_wr,
    input  logic [1:0]          req_size,
    input  logic                req_zero_extnd,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_fault,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int c_nb    = XLEN / 8;
    localparam int c_off_w = $clog2(c_nb);
    localparam logic [1:0] c_size_dword = 2'd3;
    localparam logic [2*c_nb-1:0] c_be_one = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_addr0;
    logic [c_off_w-1:0]    r_off;
    logic [1:0]            r_size;
    logic                  r_zx;
    logic                  r_wr;
    logic                  r_split;
    logic [c_nb-1:0]       r_be1;
    logic [XLEN-1:0]       r_wdata1;
    logic [XLEN-1:0]       r_rdata0;

    logic [c_off_w-1:0]    w_req_off;
    logic [3:0]            w_req_bytes;
    logic [4:0]            w_req_span;
    logic                  w_req_cross;
    logic                  w_req_fault;
    logic [ADDR_W-1:0]     w_aligned;
    logic [2*c_nb-1:0]     w_be_full;
    logic [2*XLEN-1:0]     w_wd_full;

    logic [XLEN-1:0]       w_lo;
    logic [XLEN-1:0]       w_hi;
    logic [2*XLEN-1:0]     w_shifted;
    logic [XLEN-1:0]       w_raw;
    logic [6:0]            w_lbits;
    logic [6:0]            w_shamt;
    logic [XLEN-1:0]       w_lsh;
    logic [XLEN-1:0]       w_ext;

    assign w_req_off   = req_addr[c_off_w-1:0];
    assign w_req_bytes = 4'd1 << req_size;
    assign w_req_span  = 5'(w_req_off) + 5'(w_req_bytes);
    assign w_req_cross = w_req_span > 5'(c_nb);
    assign w_req_fault = (req_size == c_size_dword && XLEN == 32) ||
                         (w_req_cross && SPLIT_MISALIGNED == 0);
    assign w_aligned   = {req_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
    // Double-width lane images: low half is beat 0, high half is beat 1.
    assign w_be_full   = ((c_be_one << w_req_bytes) - c_be_one) << w_req_off;
    assign w_wd_full   = {{XLEN{1'b0}}, req_wdata} << {w_req_off, 3'b000};

    // Beat 0 data is live on mem_rdata unless the access was split.
    assign w_lo      = (r_state == S_WAIT1) ? r_rdata0 : mem_rdata;
    assign w_hi      = (r_state == S_WAIT1) ? mem_rdata : '0;
    assign w_shifted = {w_hi, w_lo} >> {r_off, 3'b000};
    assign w_raw     = w_shifted[XLEN-1:0];
    assign w_lbits   = 7'd8 << r_size;

    always_comb begin
        w_shamt = 7'(XLEN) - w_lbits;
        w_lsh   = w_raw << w_shamt;
        if (w_lbits >= 7'(XLEN)) begin
            w_ext = w_raw;
        end else if (r_zx) begin
            w_ext = w_lsh >> w_shamt;
        end else begin
            w_ext = $signed(w_lsh) >>> w_shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_addr0   <= '0;
            r_off     <= '0;
            r_size    <= '0;
            r_zx      <= 1'b0;
            r_wr      <= 1'b0;
            r_split   <= 1'b0;
            r_be1     <= '0;
            r_wdata1  <= '0;
            r_rdata0  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_addr0   <= w_aligned;
                        r_off     <= w_req_off;
                        r_size    <= req_size;
                        r_zx      <= req_zero_extnd;
                        r_wr      <= req_wr;
                        r_split   <= w_req_cross;
                        r_be1     <= w_be_full[2*c_nb-1:c_nb];
                        r_wdata1  <= w_wd_full[2*XLEN-1:XLEN];
                        if (w_req_fault) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_rdata <= '0;
                            r_state   <= S_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_wr    <= req_wr;
                            mem_addr  <= w_aligned;
                            mem_be    <= w_be_full[c_nb-1:0];
                            mem_wdata <= w_wd_full[XLEN-1:0];
                            r_state   <= S_REQ0;
                        end
                    end
                end
                S_REQ0: begin
                    if (mem_gnt) begin
                        if (r_wr && r_split) begin
                            mem_addr  <= r_addr0 + ADDR_W'(c_nb);
                            mem_be    <= r_be1;
                            mem_wdata <= r_wdata1;
                            r_state   <= S_REQ1;
                        end else if (r_wr) begin
                            mem_req   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            r_state   <= S_RESP;
                        end else begin
                            mem_req   <= 1'b0;
                            r_state   <= S_WAIT0;
                        end
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid) begin
                        r_rdata0 <= mem_rdata;
                        if (r_split) begin
                            mem_req   <= 1'b1;
                            mem_addr  <= r_addr0 + ADDR_W'(c_nb);
                            mem_be    <= r_be1;
                            mem_wdata <= r_wdata1;
                            r_state   <= S_REQ1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= w_ext;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_REQ1: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (r_wr) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            r_state   <= S_RESP;
                        end else begin
                            r_state   <= S_WAIT1;
                        end
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= w_ext;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
